mem_copy_initiator: RTL and testbench
=====================================

Name: mem_copy_initiator

Overview:
- Bus initiator for the native valid/ready memory interface that the on-chip memory and out_byte responder already serve.
- Copies LEN 32-bit words from SRC_ADDR to DST_ADDR, one read then one write per word, with full-word strobes.
- Sits alongside the CPU core as a second initiator, behind an external arbiter, or drives the memory directly in test systems.

Parameters:
- LEN_W, 16, width of the word-count input and the progress counter.
- TIMEOUT_CYCLES, 1024, maximum cycles mem_valid may wait for mem_ready before the transfer aborts; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- src_addr  in  32  source byte address; bits [1:0] are ignored (treated as 0).
- dst_addr  in  32  destination byte address; bits [1:0] are ignored.
- len  in  LEN_W  number of words to copy.
- busy  out  1  high from the cycle after start is accepted until the FINISH state.
- done  out  1  one-cycle pulse at the end of a transfer (normal or abort).
- error  out  1  sticky timeout flag; cleared when the next start is accepted.
- words_done  out  LEN_W  count of completed word copies in the current or last transfer.
- mem_valid  out  1  request valid.
- mem_instr  out  1  tied to 0.
- mem_ready  in  1  responder completion.
- mem_addr  out  32  request address, word aligned.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b0000 for a read, 4'b1111 for a write.
- mem_rdata  in  32  read data, valid in the handshake cycle.

Behaviour:
- Reset: state=IDLE. All of the following are 0: mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, error, words_done.
- Reset mid-transfer: mem_valid drops at the next edge. There is no completion pulse.
- Handshake: a transaction completes in the cycle where mem_valid and mem_ready are both high.
  - mem_addr, mem_wdata and mem_wstrb stay stable while mem_valid is high.
  - mem_valid is low for exactly one cycle after each completion, because the responder requires a valid deassertion between requests.
- FSM states: IDLE, RD, RD_GAP, WR, WR_GAP, FINISH.
- IDLE:
  - start=1 and len!=0: latch the word-aligned src/dst and len, set words_done=0, clear error, go to RD.
  - start=1 and len=0: clear error and go straight to FINISH. No bus traffic occurs.
- RD: mem_valid=1, mem_wstrb=0, mem_addr=src pointer. On handshake, capture mem_rdata into the data register and go to RD_GAP.
- RD_GAP: mem_valid=0, then go to WR.
- WR: mem_valid=1, mem_wstrb=4'hF, mem_addr=dst pointer, mem_wdata=captured data. On handshake:
  - increment words_done;
  - src and dst pointers each increment by 4, wrapping modulo 2^32;
  - if words_done+1 equals len, go to FINISH; otherwise go to WR_GAP.
- WR_GAP: mem_valid=0, then go to RD.
- FINISH: done=1, busy=0 for one cycle, then go to IDLE.
- busy is 1 in RD, RD_GAP, WR, WR_GAP.
- Latency:
  - start sampled at edge k gives mem_valid=1 in the cycle after edge k.
  - With a zero-wait responder (mem_ready already high) each word takes 4 cycles.
  - done rises one cycle after the final write handshake.
- start while busy is ignored and has no side effects.
- Watchdog:
  - The counter resets at every RD/WR entry and increments while mem_valid=1 and mem_ready=0.
  - When it reaches TIMEOUT_CYCLES: drop mem_valid, set error=1, go to FINISH. words_done holds the completed count.
- A mem_ready that arrives while mem_valid=0 is ignored.
- mem_rdata is sampled only in the RD handshake cycle.

Decomposition:
- Package mem_copy_pkg holds:
  - the state enum (IDLE, RD, RD_GAP, WR, WR_GAP, FINISH);
  - WSTRB_READ=4'h0 and WSTRB_WORD=4'hF;
  - the default for TIMEOUT_CYCLES.
- One sub-module, bus_watchdog: a parameterised counter with clear and enable inputs and an expire output, reusable by other initiators.

Test Plan:
- Zero-wait responder, src=0x100, dst=0x200, len=3, memory[0x40..0x42]=A,B,C -> memory[0x80..0x82]=A,B,C; done pulses once, 12 cycles after the first mem_valid; words_done=3; error=0.
- Slow responder (mem_ready asserted 2 cycles after mem_valid), len=2 -> addr/wdata/wstrb stay stable throughout each wait; mem_valid is low for exactly 1 cycle between transactions; the copy is correct.
- len=0 with start -> no mem_valid ever; done=1 exactly 1 cycle after the start edge; busy stays 0.
- TIMEOUT_CYCLES=8, responder never ready, len=4 -> mem_valid drops after 8 waiting cycles; error=1; done pulses; words_done=0. A following good start clears error.
- src=0xFFFFFFFC, dst=0x10, len=2 -> read addresses are 0xFFFFFFFC then 0x00000000 (wrap); write addresses are 0x10 then 0x14.
- Assert reset while in WR with len=5 -> the next cycle has mem_valid=0, busy=0, words_done=0, state IDLE; a start pulse during busy in a separate run is ignored.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// ----------------------------------------------------------------------------
// mem_copy_pkg: shared types and constants for the memory-copy initiator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_copy_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RD_GAP = 3'd2,
    WR     = 3'd3,
    WR_GAP = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic [3:0] WSTRB_READ = 4'h0;
  localparam logic [3:0] WSTRB_WORD = 4'hF;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_watchdog.sv
// ----------------------------------------------------------------------------
// bus_watchdog: counts stalled request cycles and flags expiry at LIMIT
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (LIMIT == 0) begin : g_disabled
      logic unused_in;
      assign unused_in = ^{clk, reset, clear, enable};
      assign expire    = 1'b0;
    end else begin : g_enabled
      localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
      localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

      logic [CW-1:0] count;

      // expire fires during the LIMIT-th enabled cycle, so the owner can
      // retire the request at the following edge
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          count <= '0;
        end else if (enable && (count != LAST)) begin
          count <= count + 1'b1;
        end
      end

      assign expire = enable && (count == LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_copy_initiator.sv
// ----------------------------------------------------------------------------
// mem_copy_initiator: copies len words src->dst over the valid/ready bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_copy_initiator
  import mem_copy_pkg::*;
#(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  output logic             mem_instr,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  state_t           state;
  state_t           next_state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      data_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] words_next;
  logic             hs;
  logic             expire;
  logic             last_word;

  assign mem_valid  = (state == RD) || (state == WR);
  assign mem_instr  = 1'b0;
  assign busy       = (state == RD) || (state == RD_GAP) ||
                      (state == WR) || (state == WR_GAP);
  assign done       = (state == FINISH);
  assign hs         = mem_valid && mem_ready;
  assign words_next = words_done + 1'b1;
  assign last_word  = (words_next == len_r);

  // Counter is held clear whenever no request is outstanding, which also
  // restarts it on every RD/WR entry since both are entered from idle-bus states
  bus_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (!mem_valid),
    .enable (mem_valid && !mem_ready),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      data_r     <= '0;
      len_r      <= '0;
      words_done <= '0;
      error      <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
            if (len != '0) begin
              src_ptr    <= word_align(src_addr);
              dst_ptr    <= word_align(dst_addr);
              len_r      <= len;
              words_done <= '0;
            end
          end
        end
        RD: begin
          if (hs) begin
            data_r <= mem_rdata;
          end else if (expire) begin
            error <= 1'b1;
          end
        end
        WR: begin
          if (hs) begin
            words_done <= words_next;
            src_ptr    <= src_ptr + 32'd4;
            dst_ptr    <= dst_ptr + 32'd4;
          end else if (expire) begin
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (len == '0) ? FINISH : RD;
      RD: begin
        if (hs)          next_state = RD_GAP;
        else if (expire) next_state = FINISH;
      end
      RD_GAP:  next_state = WR;
      WR: begin
        if (hs)          next_state = last_word ? FINISH : WR_GAP;
        else if (expire) next_state = FINISH;
      end
      WR_GAP:  next_state = RD;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = WSTRB_READ;
    case (state)
      RD: mem_addr = src_ptr;
      WR: begin
        mem_addr  = dst_ptr;
        mem_wdata = data_r;
        mem_wstrb = WSTRB_WORD;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_initiator.sv
// ----------------------------------------------------------------------------
// tb_mem_copy_initiator: directed self-checking bench for mem_copy_initiator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_copy_initiator;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } xact_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, error, mem_valid, mem_instr, mem_ready;
  logic [15:0] words_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic [31:0] mem [0:255];
  int          mode = 0;        // 0: always ready, 1: ready after 2 waits, 2: never
  int          wait_cnt = 0;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int done_cnt = 0, valid_cnt = 0, busy_cnt = 0, hs_cnt = 0;
  int stab_chk = 0, stab_viol = 0, gap_chk = 0, gap_viol = 0;
  int first_valid_cyc = 0, done_cyc = 0, low_run = 0;
  logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_busy = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic [3:0]  prev_wstrb = '0;
  xact_t       log_q[$];

  mem_copy_initiator #(
    .LEN_W          (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .words_done (words_done),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (wait_cnt >= 2) : 1'b0;
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end

  // Bus monitor / memory model, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_valid) valid_cnt++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mem_valid && prev_valid && !prev_hs) begin
      stab_chk++;
      if (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_wstrb !== prev_wstrb)
        stab_viol++;
    end
    if (mem_valid && !prev_valid) begin
      if (prev_busy) begin
        gap_chk++;
        if (low_run != 1) gap_viol++;
      end else begin
        first_valid_cyc = cyc;
      end
    end
    if (mem_valid) low_run = 0;
    else           low_run++;
    if (mem_valid && mem_ready) begin
      hs_cnt++;
      log_q.push_back('{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb});
      if (mem_wstrb == 4'hF) mem[mem_addr[9:2]] = mem_wdata;
    end
    prev_valid = mem_valid;
    prev_hs    = mem_valid && mem_ready;
    prev_busy  = busy;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_wstrb = mem_wstrb;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    done_cnt = 0; valid_cnt = 0; busy_cnt = 0; hs_cnt = 0;
    stab_chk = 0; stab_viol = 0; gap_chk = 0; gap_viol = 0;
    log_q.delete();
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_error", error, 0);
    chk("rst_words", words_done, 0);
    chk("rst_instr", mem_instr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait copy of 3 words 0x100 -> 0x200
    mode = 0;
    mem[8'h40] = 32'hA0A0_0001;
    mem[8'h41] = 32'hB0B0_0002;
    mem[8'h42] = 32'hC0C0_0003;
    clr_mon();
    start_xfer(32'h100, 32'h200, 16'd3);
    chk("t1_valid_after_start", mem_valid, 1);
    chk("t1_busy", busy, 1);
    wait_done("t1_done", 40);
    repeat (3) @(negedge clk);
    // done falls in the 12th cycle counting the first mem_valid cycle as the 1st
    chk("t1_done_latency", done_cyc - first_valid_cyc, 11);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_mem0", mem[8'h80], 32'hA0A0_0001);
    chk("t1_mem1", mem[8'h81], 32'hB0B0_0002);
    chk("t1_mem2", mem[8'h82], 32'hC0C0_0003);
    chk("t1_words", words_done, 3);
    chk("t1_error", error, 0);
    chk("t1_gap_viol", gap_viol, 0);
    chk("t1_gap_chk", gap_chk, 5);

    // Slow responder, 2 words 0x300 -> 0x380
    mode = 1;
    mem[8'hC0] = 32'h1234_5678;
    mem[8'hC1] = 32'h9ABC_DEF0;
    clr_mon();
    start_xfer(32'h300, 32'h380, 16'd2);
    wait_done("t2_done", 60);
    repeat (3) @(negedge clk);
    chk("t2_mem0", mem[8'hE0], 32'h1234_5678);
    chk("t2_mem1", mem[8'hE1], 32'h9ABC_DEF0);
    chk("t2_stab_viol", stab_viol, 0);
    chk("t2_stab_chk", stab_chk, 8);
    chk("t2_gap_viol", gap_viol, 0);
    chk("t2_gap_chk", gap_chk, 3);
    chk("t2_words", words_done, 2);

    // len = 0: no bus traffic, done one cycle after the start edge
    mode = 0;
    clr_mon();
    start_xfer(32'h100, 32'h200, 16'd0);
    chk("t3_done_next", done, 1);
    chk("t3_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("t3_valid_cnt", valid_cnt, 0);
    chk("t3_busy_cnt", busy_cnt, 0);
    chk("t3_done_cnt", done_cnt, 1);

    // Watchdog: responder never ready
    mode = 2;
    clr_mon();
    start_xfer(32'h100, 32'h200, 16'd4);
    wait_done("t4_done", 40);
    chk("t4_error_at_done", error, 1);
    repeat (3) @(negedge clk);
    chk("t4_valid_cnt", valid_cnt, 8);
    chk("t4_error_sticky", error, 1);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_words", words_done, 0);
    chk("t4_hs_cnt", hs_cnt, 0);
    mode = 0;
    start_xfer(32'h100, 32'h240, 16'd1);
    chk("t4_error_cleared", error, 0);
    wait_done("t4b_done", 20);
    repeat (2) @(negedge clk);
    chk("t4b_mem", mem[8'h90], 32'hA0A0_0001);
    chk("t4b_words", words_done, 1);

    // Address wrap on the source pointer
    mem[8'hFF] = 32'hDEAD_BEEF;
    mem[8'h00] = 32'hCAFE_F00D;
    clr_mon();
    start_xfer(32'hFFFF_FFFC, 32'h10, 16'd2);
    wait_done("t5_done", 40);
    repeat (2) @(negedge clk);
    chk("t5_log_size", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t5_rd0_addr", log_q[0].addr, 32'hFFFF_FFFC);
      chk("t5_rd0_strb", log_q[0].wstrb, 4'h0);
      chk("t5_wr0_addr", log_q[1].addr, 32'h10);
      chk("t5_wr0_data", log_q[1].wdata, 32'hDEAD_BEEF);
      chk("t5_wr0_strb", log_q[1].wstrb, 4'hF);
      chk("t5_rd1_addr", log_q[2].addr, 32'h0);
      chk("t5_wr1_addr", log_q[3].addr, 32'h14);
      chk("t5_wr1_data", log_q[3].wdata, 32'hCAFE_F00D);
    end

    // Reset during the second WR of a 5-word copy
    mode = 1;
    clr_mon();
    start_xfer(32'h100, 32'h200, 16'd5);
    begin
      int n = 0;
      while (!(mem_valid && mem_wstrb == 4'hF && words_done == 16'd1) && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_in_wr2", mem_valid && mem_wstrb == 4'hF && words_done == 16'd1, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_valid", mem_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_words", words_done, 0);
    chk("t6_done", done, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_idle_valid", mem_valid, 0);

    // start pulse while busy is ignored
    mode = 0;
    clr_mon();
    start_xfer(32'h100, 32'h280, 16'd2);
    @(negedge clk);
    src_addr = 32'h300;
    dst_addr = 32'h3C0;
    len      = 16'd1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done("t7_done", 40);
    repeat (3) @(negedge clk);
    chk("t7_words", words_done, 2);
    chk("t7_done_cnt", done_cnt, 1);
    chk("t7_hs_cnt", hs_cnt, 4);
    chk("t7_mem0", mem[8'hA0], 32'hA0A0_0001);
    chk("t7_mem1", mem[8'hA1], 32'hB0B0_0002);
    chk("t7_no_stray", mem[8'hF0], 32'h0);
    if (log_q.size() == 4) chk("t7_rd1_addr", log_q[2].addr, 32'h104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
